uart_tx_ctrl: RTL and testbench

UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

---
 rtl/uart_tx_pkg.sv | 36 +++
 rtl/parity_calc.sv | 31 +++
 rtl/uart_tx_ctrl.sv | 95 +++++++++
 tb/tb_uart_tx_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_pkg
// Purpose  : Shared FSM state encoding and line-mux select constants.
// Revision : 1.0
// ============================================================================
package uart_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    localparam logic [1:0] START_SEL = 2'b00;
    localparam logic [1:0] STOP_SEL  = 2'b01;
    localparam logic [1:0] DATA_SEL  = 2'b10;
    localparam logic [1:0] PAR_SEL   = 2'b11;

    // IDLE shares the stop select so the downstream line rests high.
    function automatic logic [1:0] state_to_sel(input tx_state_e s);
        logic [1:0] sel;
        sel = STOP_SEL;
        case (s)
            ST_START:  sel = START_SEL;
            ST_DATA:   sel = DATA_SEL;
            ST_PARITY: sel = PAR_SEL;
            default:   sel = STOP_SEL;
        endcase
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/parity_calc.sv
`default_nettype none
// ============================================================================
// Module   : parity_calc
// Purpose  : Registered even/odd parity of a data word, captured on load_i.
// Revision : 1.0
// ============================================================================
module parity_calc #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  par_typ_i,
    output logic                  parity_o
);

    logic parity_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else if (load_i) begin
            parity_q <= (^data_i) ^ par_typ_i;
        end
    end

    assign parity_o = parity_q;

endmodule
`default_nettype wire

// File: rtl/uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_ctrl
// Purpose  : UART transmit sequencer driving the line-select mux, data bit
//            and parity bit for one frame per accepted DATA_VALID.
// Revision : 1.0
// ============================================================================
module uart_tx_ctrl
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [1:0]            mux_sel,
    output logic                  serial_data,
    output logic                  parity_bit,
    output logic                  busy
);

    localparam int             CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_WIDTH - 1);

    tx_state_e             state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  par_en_q;
    logic                  load_frame;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        load_frame = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (DATA_VALID) begin
                    load_frame = 1'b1;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                state_d = ST_DATA;
                cnt_d   = '0;
            end
            ST_DATA: begin
                if (cnt_q == LAST_IDX) begin
                    state_d = par_en_q ? ST_PARITY : ST_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_PARITY: state_d = ST_STOP;
            ST_STOP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            data_q   <= '0;
            par_en_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (load_frame) begin
                data_q   <= P_DATA;
                par_en_q <= PAR_EN;
            end
        end
    end

    parity_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity_calc (
        .clk       (CLK),
        .rst       (RST),
        .load_i    (load_frame),
        .data_i    (P_DATA),
        .par_typ_i (PAR_TYP),
        .parity_o  (parity_bit)
    );

    // Held at 0 outside DATA so the bit never toggles between frames.
    assign serial_data = (state_q == ST_DATA) ? data_q[cnt_q] : 1'b0;
    assign mux_sel     = state_to_sel(state_q);
    assign busy        = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_ctrl
// Purpose  : Scoreboard bench for uart_tx_ctrl: per-cycle expected line state.
// Revision : 1.0
// ============================================================================
module tb_uart_tx_ctrl;

    logic       clk;
    logic       rst;
    logic [7:0] p_data;
    logic       data_valid;
    logic       par_en;
    logic       par_typ;
    logic [1:0] mux_sel;
    logic       serial_data;
    logic       parity_bit;
    logic       busy;

    int n_chk;
    int n_err;
    logic mon_en;

    typedef struct packed {
        logic [1:0] sel;
        logic       busy;
        logic       chk_ser;
        logic       ser;
        logic       chk_par;
        logic       par;
    } exp_t;

    exp_t exp_q[$];

    uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
        .CLK         (clk),
        .RST         (rst),
        .P_DATA      (p_data),
        .DATA_VALID  (data_valid),
        .PAR_EN      (par_en),
        .PAR_TYP     (par_typ),
        .mux_sel     (mux_sel),
        .serial_data (serial_data),
        .parity_bit  (parity_bit),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Leading IDLE cycle (request visible, not yet accepted), then the frame.
    task automatic push_frame(input logic [7:0] d, input logic pen, input logic ptyp,
                              input int ncyc);
        exp_t e;
        logic p;
        int   idx;
        p   = (^d) ^ ptyp;
        idx = 0;
        e = '{sel: 2'b01, busy: 1'b0, chk_ser: 1'b0, ser: 1'b0, chk_par: 1'b0, par: 1'b0};
        if (idx < ncyc) exp_q.push_back(e);
        idx++;
        e = '{sel: 2'b00, busy: 1'b1, chk_ser: 1'b0, ser: 1'b0, chk_par: 1'b1, par: p};
        if (idx < ncyc) exp_q.push_back(e);
        idx++;
        for (int i = 0; i < 8; i++) begin
            e = '{sel: 2'b10, busy: 1'b1, chk_ser: 1'b1, ser: d[i], chk_par: 1'b1, par: p};
            if (idx < ncyc) exp_q.push_back(e);
            idx++;
        end
        if (pen) begin
            e = '{sel: 2'b11, busy: 1'b1, chk_ser: 1'b0, ser: 1'b0, chk_par: 1'b1, par: p};
            if (idx < ncyc) exp_q.push_back(e);
            idx++;
        end
        e = '{sel: 2'b01, busy: 1'b1, chk_ser: 1'b0, ser: 1'b0, chk_par: 1'b1, par: p};
        if (idx < ncyc) exp_q.push_back(e);
    endtask

    task automatic push_idle(input logic chk_ser, input logic par);
        exp_t e;
        e = '{sel: 2'b01, busy: 1'b0, chk_ser: chk_ser, ser: 1'b0, chk_par: 1'b1, par: par};
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (mon_en && exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("mux_sel", 32'(mux_sel), 32'(e.sel));
            check("busy", 32'(busy), 32'(e.busy));
            if (e.chk_ser) check("serial_data", 32'(serial_data), 32'(e.ser));
            if (e.chk_par) check("parity_bit", 32'(parity_bit), 32'(e.par));
        end
    end

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        check("drain_timeout", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic pen, input logic ptyp);
        p_data     = d;
        par_en     = pen;
        par_typ    = ptyp;
        data_valid = 1'b1;
        push_frame(d, pen, ptyp, 100);
        @(posedge clk);
        #1;
        data_valid = 1'b0;
    endtask

    initial begin
        n_chk      = 0;
        n_err      = 0;
        mon_en     = 1'b0;
        rst        = 1'b1;
        p_data     = 8'h00;
        data_valid = 1'b1;
        par_en     = 1'b1;
        par_typ    = 1'b1;

        // Reset must win over a simultaneous DATA_VALID.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mux_sel", 32'(mux_sel), 32'h1);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_serial", 32'(serial_data), 32'h0);
        check("rst_parity", 32'(parity_bit), 32'h0);
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        rst        = 1'b0;
        mon_en     = 1'b1;
        @(posedge clk);
        #1;

        // Even and odd parity on 0xA5
        send(8'hA5, 1'b1, 1'b0);
        drain();
        send(8'hA5, 1'b1, 1'b1);
        drain();

        // No parity on 0x00, line returns to idle
        send(8'h00, 1'b0, 1'b0);
        push_idle(1'b0, 1'b0);
        drain();

        // Ignored request: 0xFF presented mid-frame must not be sent
        p_data     = 8'h3C;
        par_en     = 1'b1;
        par_typ    = 1'b1;
        data_valid = 1'b1;
        push_frame(8'h3C, 1'b1, 1'b1, 100);
        @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        p_data  = 8'hFF;
        par_en  = 1'b0;
        par_typ = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        data_valid = 1'b0;
        drain();

        // Reset during the fourth data bit aborts the frame
        p_data     = 8'hC3;
        par_en     = 1'b1;
        par_typ    = 1'b0;
        data_valid = 1'b1;
        push_frame(8'hC3, 1'b1, 1'b0, 6);
        push_idle(1'b1, 1'b0);
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        drain();
        send(8'h96, 1'b1, 1'b1);
        drain();

        // Back-to-back frames with DATA_VALID held high
        p_data     = 8'h55;
        par_en     = 1'b1;
        par_typ    = 1'b0;
        data_valid = 1'b1;
        push_frame(8'h55, 1'b1, 1'b0, 100);
        push_frame(8'hAA, 1'b1, 1'b1, 100);
        push_idle(1'b0, 1'b1);
        @(posedge clk);
        #1;
        p_data  = 8'hAA;
        par_typ = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        data_valid = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
